// File: rtl/fifo_pkg.sv
// fifo_pkg: definitions shared by the FIFO consumer stage.
//   DATA_WIDTH_DEFAULT : default FIFO word width
//   OUT_DEPTH          : number of entries in the output buffer
//   state_t            : read-sequencer states (ST_IDLE, ST_RD, ST_CAP)
//   in_flight()        : true while a FIFO read is issued but not yet captured
package fifo_pkg;

  localparam int DATA_WIDTH_DEFAULT = 8;
  localparam int OUT_DEPTH          = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_CAP  = 2'd2
  } state_t;

  // A read occupies a buffer slot from the moment it is issued (RD) until
  // the word lands in the buffer at the end of CAP.
  function automatic logic in_flight(input state_t s);
    return (s == ST_RD) || (s == ST_CAP);
  endfunction

endpackage

// File: rtl/fifo_drain_out_skid_buf.sv
// out_skid_buf: 2-entry circular output buffer.
// Ports:
//   clk, Reset     : clock, synchronous active-low reset
//   push/push_data : write one word at the tail
//   pop            : retire the head word (ignored when empty)
//   occupancy      : number of stored words (0..2)
//   out_valid      : buffer holds at least one word
//   out_data       : head word, driven straight from storage registers
module out_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [1:0]            occupancy,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data
);

  logic [DATA_WIDTH-1:0] entry_reg [OUT_DEPTH];
  logic [OUT_DEPTH-1:0]  wr_en;
  logic                  head_reg;
  logic                  tail_reg;
  logic [1:0]            count_reg;
  logic                  do_pop;

  assign do_pop = pop && (count_reg != 2'd0);

  genvar gi;
  generate
    for (gi = 0; gi < OUT_DEPTH; gi++) begin : g_wr
      assign wr_en[gi] = push && (tail_reg == 1'(gi));
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!Reset) begin
      for (int i = 0; i < OUT_DEPTH; i++) entry_reg[i] <= '0;
      head_reg  <= 1'b0;
      tail_reg  <= 1'b0;
      count_reg <= 2'd0;
    end else begin
      for (int i = 0; i < OUT_DEPTH; i++) begin
        if (wr_en[i]) entry_reg[i] <= push_data;
      end
      if (push)   tail_reg <= ~tail_reg;
      if (do_pop) head_reg <= ~head_reg;
      // Simultaneous push and pop leaves the count unchanged.
      case ({push, do_pop})
        2'b10:   count_reg <= count_reg + 2'd1;
        2'b01:   count_reg <= count_reg - 2'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign occupancy = count_reg;
  assign out_valid = (count_reg != 2'd0);
  assign out_data  = entry_reg[head_reg];

  // The read sequencer reserves space before issuing, so a push never
  // meets a full buffer.
  a_no_push_when_full: assert property (@(posedge clk) disable iff (!Reset)
    !(push && count_reg == 2'd2));

endmodule

// File: rtl/fifo_drain.sv
// fifo_drain: consumer stage that pops words from a FIFO with one-cycle read
// latency and re-presents them on a valid/ready interface.
// Ports:
//   clk, Reset       : clock, synchronous active-low reset (priority over Enable)
//   Enable           : global enable; low freezes all state and blocks reads
//   FIFO_data_out    : FIFO read data, valid the cycle after read_enable
//   FIFO_empty       : FIFO empty flag
//   read_enable      : pop request to the FIFO
//   out_data         : head word of the output buffer
//   out_valid        : out_data holds a valid word
//   out_ready        : downstream accepts out_data this cycle
//   words_delivered  : wrapping count of completed output handshakes
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEFAULT,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  Reset,
  input  logic                  Enable,
  input  logic [DATA_WIDTH-1:0] FIFO_data_out,
  input  logic                  FIFO_empty,
  output logic                  read_enable,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  words_delivered
);

  state_t               state_reg, state_next;
  logic [CNT_WIDTH-1:0] cnt_reg;
  logic [1:0]           occupancy;
  logic [1:0]           occ_after_pop;
  logic                 handshake;
  logic                 buf_push;
  logic                 space_ok;

  // Buffer and counter only move while enabled.
  assign handshake = out_valid && out_ready && Enable;
  assign buf_push  = (state_reg == ST_CAP) && Enable;

  // Room for one more read: words held after this cycle's pop plus the read
  // already in flight must leave at least one free slot.
  assign occ_after_pop = occupancy - {1'b0, handshake};
  assign space_ok      = (occ_after_pop + {1'b0, in_flight(state_reg)}) < 2'd2;

  always_ff @(posedge clk) begin
    if (!Reset) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else if (Enable) begin
      state_reg <= state_next;
      if (handshake) cnt_reg <= cnt_reg + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    state_next  = state_reg;
    read_enable = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!FIFO_empty && space_ok) state_next = ST_RD;
      end
      ST_RD: begin
        read_enable = Enable;
        state_next  = ST_CAP;
      end
      ST_CAP: begin
        // FIFO_empty already reflects the pop issued in RD.
        state_next = (!FIFO_empty && space_ok) ? ST_RD : ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  out_skid_buf #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_buf (
    .clk       (clk),
    .Reset     (Reset),
    .push      (buf_push),
    .push_data (FIFO_data_out),
    .pop       (handshake),
    .occupancy (occupancy),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign words_delivered = cnt_reg;

  a_no_back_to_back: assert property (@(posedge clk) disable iff (!Reset)
    read_enable |=> !read_enable);
  a_no_read_when_empty: assert property (@(posedge clk) disable iff (!Reset)
    !(read_enable && FIFO_empty));

endmodule
